// File: rtl/f1_truth_table_sweeper.sv
// Walks {a,b,c,d} through all 16 minterms, samples f1 once per minterm after a
// settle window, and scores the measured truth table against a golden constant.
module f1_truth_table_sweeper #(
   parameter int          SETTLE   = 1,
   parameter logic [15:0] EXPECTED = 16'h8DC5
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   output logic        a,
   output logic        b,
   output logic        c,
   output logic        d,
   input  logic        f1,
   output logic        busy,
   output logic        done,
   output logic [15:0] truth_table,
   output logic [4:0]  err_cnt,
   output logic        match
);

   localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(SETTLE - 1);

   typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_CAPTURE, S_DONE} state_t;

   state_t         state, state_nxt;
   logic [3:0]     idx;
   logic [CW-1:0]  cnt;
   logic           miss;
   logic [4:0]     err_nxt;

   assign miss    = (f1 != EXPECTED[idx]);
   assign err_nxt = err_cnt + {4'd0, miss};

   always_ff @(posedge clk) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:    if (start) state_nxt = S_SETTLE;
         S_SETTLE:  if (cnt == CNT_LAST) state_nxt = S_CAPTURE;
         S_CAPTURE: state_nxt = (idx == 4'd15) ? S_DONE : S_SETTLE;
         S_DONE:    state_nxt = S_IDLE;
         default:   state_nxt = S_IDLE;
      endcase
   end

   // Datapath and registered outputs; the vector register mirrors idx while
   // sweeping and drops back to zero on entry to DONE.
   always_ff @(posedge clk) begin
      if (rst) begin
         idx          <= 4'd0;
         cnt          <= '0;
         {a, b, c, d} <= 4'd0;
         busy         <= 1'b0;
         done         <= 1'b0;
         truth_table  <= 16'd0;
         err_cnt      <= 5'd0;
         match        <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  idx          <= 4'd0;
                  cnt          <= '0;
                  {a, b, c, d} <= 4'd0;
                  busy         <= 1'b1;
                  truth_table  <= 16'd0;
                  err_cnt      <= 5'd0;
                  match        <= 1'b0;
               end
            end
            S_SETTLE: cnt <= cnt + CW'(1);
            S_CAPTURE: begin
               truth_table[idx] <= f1;
               err_cnt          <= err_nxt;
               cnt              <= '0;
               if (idx == 4'd15) begin
                  busy         <= 1'b0;
                  done         <= 1'b1;
                  match        <= (err_nxt == 5'd0);
                  {a, b, c, d} <= 4'd0;
               end else begin
                  idx          <= idx + 4'd1;
                  {a, b, c, d} <= idx + 4'd1;
               end
            end
            S_DONE: begin
               done <= 1'b0;
               idx  <= 4'd0;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_f1_truth_table_sweeper.sv
// Bench for f1_truth_table_sweeper: drives an F1 stand-in from a lookup table
// and checks every cycle of each sweep against a cycle-level reference.
module tb_f1_truth_table_sweeper;

   logic clk = 1'b0;
   logic rst;
   logic start1, start3;
   logic a1, b1, c1, d1, a3, b3, c3, d3;
   logic f1_1, f1_3;
   logic busy1, done1, match1, busy3, done3, match3;
   logic [15:0] tt1, tt3;
   logic [4:0]  ec1, ec3;

   logic [15:0] tbl1, tbl3;
   logic        glitch3;
   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   assign f1_1 = tbl1[{a1, b1, c1, d1}];
   assign f1_3 = tbl3[{a3, b3, c3, d3}] ^ glitch3;

   f1_truth_table_sweeper #(.SETTLE(1)) dut1 (
      .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1), .c(c1), .d(d1),
      .f1(f1_1), .busy(busy1), .done(done1), .truth_table(tt1),
      .err_cnt(ec1), .match(match1));

   f1_truth_table_sweeper #(.SETTLE(3)) dut3 (
      .clk(clk), .rst(rst), .start(start3), .a(a3), .b(b3), .c(c3), .d(d3),
      .f1(f1_3), .busy(busy3), .done(done3), .truth_table(tt3),
      .err_cnt(ec3), .match(match3));

   function automatic logic ref_f1(input int i);
      logic ra, rb, rc, rd;
      {ra, rb, rc, rd} = 4'(i);
      return (!rb && !rd) || (!ra && rb && rc) || (ra && rc && rd);
   endfunction

   function automatic logic [15:0] ref_table();
      logic [15:0] t;
      for (int i = 0; i < 16; i++) t[i] = ref_f1(i);
      return t;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic samp(input int s, output logic [3:0] v, output logic bz, output logic dn,
                       output logic [15:0] tt, output logic [4:0] ec, output logic mt);
      if (s == 1) begin
         v = {a1, b1, c1, d1}; bz = busy1; dn = done1; tt = tt1; ec = ec1; mt = match1;
      end else begin
         v = {a3, b3, c3, d3}; bz = busy3; dn = done3; tt = tt3; ec = ec3; mt = match3;
      end
   endtask

   task automatic chk_reset_vals(input int s, input string tag);
      logic [3:0] v; logic bz, dn, mt; logic [15:0] tt; logic [4:0] ec;
      samp(s, v, bz, dn, tt, ec, mt);
      chk({tag, "_all"}, {v, bz, dn, tt, ec, mt}, 32'd0);
   endtask

   // One full sweep starting from IDLE; returns in the first IDLE cycle after done.
   task automatic run(input int s, input logic [15:0] tbl, input bit hold);
      logic [3:0] v; logic bz, dn, mt; logic [15:0] tt; logic [4:0] ec;
      int len, exp_err;
      len = 16 * (s + 1);
      exp_err = 0;
      for (int i = 0; i < 16; i++) if (tbl[i] != ref_f1(i)) exp_err++;
      if (s == 1) begin tbl1 = tbl; start1 = 1'b1; end
      else        begin tbl3 = tbl; start3 = 1'b1; end
      @(posedge clk); #1;
      if (!hold) begin start1 = 1'b0; start3 = 1'b0; end
      for (int j = 1; j <= len; j++) begin
         // Corrupt f1 on settle cycles only; capture cycles stay clean.
         if (s == 3) glitch3 = (((j - 1) % 4) == 0) ||
                               ((((j - 1) % 4) != 3) && ($urandom_range(0, 1) == 1));
         samp(s, v, bz, dn, tt, ec, mt);
         chk("sweep_busy", {31'd0, bz}, 32'd1);
         chk("sweep_done_low", {31'd0, dn}, 32'd0);
         chk("sweep_vector", {28'd0, v}, 32'((j - 1) / (s + 1)));
         @(posedge clk); #1;
      end
      glitch3 = 1'b0;
      samp(s, v, bz, dn, tt, ec, mt);
      chk("done_pulse", {30'd0, dn, bz}, 32'b10);
      chk("done_vector", {28'd0, v}, 32'd0);
      chk("done_table", {16'd0, tt}, {16'd0, tbl});
      chk("done_err_cnt", {27'd0, ec}, 32'(exp_err));
      chk("done_match", {31'd0, mt}, {31'd0, exp_err == 0});
      @(posedge clk); #1;
      samp(s, v, bz, dn, tt, ec, mt);
      chk("idle_after_done", {30'd0, dn, bz}, 32'd0);
      chk("idle_retain", {11'd0, tt, ec}, {11'd0, tbl, 5'(exp_err)});
   endtask

   initial begin
      logic [15:0] model;
      bit found;
      int at;
      model   = ref_table();
      rst     = 1'b1;
      start1  = 1'b0;
      start3  = 1'b0;
      glitch3 = 1'b0;
      tbl1    = model;
      tbl3    = model;
      repeat (3) @(posedge clk);
      #1;
      chk_reset_vals(1, "reset1");
      chk_reset_vals(3, "reset3");
      chk("model_const", {16'd0, model}, 32'h8DC5);
      rst = 1'b0;
      @(posedge clk); #1;

      run(1, model, 1'b0);
      run(1, 16'h0000, 1'b0);
      run(1, ~model, 1'b0);
      for (int r = 0; r < 3; r++) run(1, 16'($urandom), 1'b0);

      // start held high: one done, then a second sweep only from IDLE
      run(1, model, 1'b1);
      @(posedge clk); #1;
      chk("hold_second_busy", {31'd0, busy1}, 32'd1);
      chk("hold_second_vec0", {28'd0, a1, b1, c1, d1}, 32'd0);
      repeat (4) @(posedge clk);
      #1;
      start1 = 1'b0;
      found = 1'b0;
      at = -1;
      for (int k = 0; k < 60 && !found; k++) begin
         @(posedge clk); #1;
         if (done1) begin found = 1'b1; at = k; end
      end
      chk("hold_second_done_seen", {31'd0, found}, 32'd1);
      chk("hold_second_done_time", 32'(at), 32'd27);
      chk("hold_second_table", {16'd0, tt1}, {16'd0, model});

      // reset 10 cycles into a sweep
      @(posedge clk); #1;
      tbl1 = model;
      start1 = 1'b1;
      @(posedge clk); #1;
      start1 = 1'b0;
      repeat (9) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk_reset_vals(1, "midsweep_reset");
      for (int k = 0; k < 40; k++) begin
         chk("post_reset_quiet", {30'd0, done1, busy1}, 32'd0);
         @(posedge clk); #1;
      end
      run(1, model, 1'b0);

      run(3, model, 1'b0);
      run(3, 16'($urandom), 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/f1_truth_table_sweeper.md
Name: f1_truth_table_sweeper

Overview:
- Sequential exerciser for the 4-input F1 function block.
- Sits directly upstream of F1 and drives its a, b, c, d inputs through all 16 minterms.
- Samples the F1 output for each minterm and assembles the measured 16-entry truth table.
- Compares the table against a golden constant and reports pass/fail plus a mismatch count through a start/busy/done handshake.

Parameters:
- SETTLE, 1, cycles each input vector is held before f1 is sampled; legal range is ≥1.
- EXPECTED, 16'h8DC5, golden truth table, bit i = F1({a,b,c,d}=i) with a as MSB; the default encodes f1 = b'd' + a'bc + acd.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  sweep request; sampled only in IDLE.
- a  output  1  vector bit 3 (MSB), driven to F1.
- b  output  1  vector bit 2, driven to F1.
- c  output  1  vector bit 1, driven to F1.
- d  output  1  vector bit 0, driven to F1.
- f1  input  1  response from the F1 block.
- busy  output  1  high while a sweep is in progress.
- done  output  1  one-cycle pulse when the sweep completes.
- table  output  16  measured truth table; bit i holds f1 sampled at minterm i.
- err_cnt  output  5  number of minterms where table[i] != EXPECTED[i] (0..16).
- match  output  1  high when err_cnt == 0; valid from the done pulse onward.

Behaviour:
- Interface: one clock; reset is synchronous and active-high. Ports are named clk and rst.
- Reset values: {a,b,c,d}=0, busy=0, done=0, table=0, err_cnt=0, match=0, state=IDLE, idx=0, settle counter=0.
- Reset mid-sweep aborts the sweep. On the next cycle every output is at its reset value, and no done pulse is generated.
- States: IDLE, SETTLE, CAPTURE, DONE. All outputs are registered.
- IDLE:
  - start=1 at edge N enters SETTLE with idx=0 and cnt=0.
  - At the same edge, table, err_cnt and match are cleared and busy is set.
  - start=0 holds IDLE; previous table, err_cnt and match are retained.
- SETTLE:
  - {a,b,c,d} = idx; cnt increments each cycle.
  - When cnt == SETTLE-1, the next state is CAPTURE.
- CAPTURE:
  - At the edge leaving CAPTURE, table[idx] <= f1.
  - If f1 != EXPECTED[idx], err_cnt increments.
  - If idx == 15, go to DONE and load match <= (final err_cnt == 0), including this cycle's compare.
  - Otherwise idx increments, cnt resets to 0, and the state returns to SETTLE.
  - The vector is held stable through CAPTURE.
- DONE:
  - done=1 and busy=0 for exactly one cycle, then IDLE.
  - {a,b,c,d} returns to 0 on entry to DONE.
- Timing:
  - Each minterm occupies SETTLE+1 cycles.
  - busy is high from cycle N+1 through N+16·(SETTLE+1).
  - done is high in cycle N+16·(SETTLE+1)+1 (N+33 for SETTLE=1).
- Start handling: start is ignored while busy or done is high, including when start is held high. No queuing; a new start is accepted only in IDLE.
- f1 is sampled only in CAPTURE. Values on f1 during SETTLE cycles have no effect.
- err_cnt is 5 bits wide and saturates naturally at 16 (max 16 increments); no wrap is possible.
- idx wraps 15→0 only via DONE→IDLE; it never advances past 15 within a sweep.

Test Plan:
- Bench models f1 = b'd' + a'bc + acd, SETTLE=1; pulse start at edge N → vector walks 0..15, changing every 2 cycles; done at N+33; table=16'h8DC5, err_cnt=0, match=1.
- f1 tied to 0 → table=16'h0000, err_cnt=8, match=0, done at N+33.
- f1 = inverted model → table=16'h723A, err_cnt=16, match=0.
- start held high for 40 cycles → exactly one done pulse at N+33; a second sweep starts only after IDLE is re-entered.
- rst asserted 10 cycles into a sweep → next cycle all outputs are 0 and state is IDLE, with no done; a fresh start re-sweeps from idx=0 and yields 16'h8DC5.
- SETTLE=3 instance, f1 forced wrong during the first SETTLE cycle of each minterm → vector changes every 4 cycles; done at N+65; table=16'h8DC5 (glitches not captured).
